// File: rtl/seq_detect_counter_if.sv
// Bus between the Basys 3 front-end board pins and the sequence-detecting counter.
// The master drives the raw switch and buttons; the slave returns count, pulse and LED state.
interface seq_detect_counter_if;
  logic        bit_sw;
  logic        step_btn;
  logic        clear_btn;
  logic [15:0] count;
  logic        detected;
  logic [2:0]  state_out;
  logic [3:0]  last_bits;

  modport master (
    output bit_sw, step_btn, clear_btn,
    input  count, detected, state_out, last_bits
  );

  modport slave (
    input  bit_sw, step_btn, clear_btn,
    output count, detected, state_out, last_bits
  );
endinterface

// File: rtl/seq_detect_counter.sv
// Synchronizers, step-button debouncer and overlapping 1101 detector with a
// wrapping 0..COUNT_MAX detection counter for the seven-segment display.
module seq_detect_counter #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int COUNT_MAX       = 9999
) (
  input logic                 clk,
  input logic                 reset,
  seq_detect_counter_if.slave bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S11   = 3'd2,
    S110  = 3'd3,
    S1101 = 3'd4
  } state_t;

  logic [1:0]      bit_sync_r;
  logic [1:0]      step_sync_r;
  logic [1:0]      clear_sync_r;
  logic [DB_W-1:0] db_cnt_r;
  logic            db_level_r;
  logic            step_prev_r;
  logic            step_r;
  state_t          state_r;
  logic [15:0]     count_r;
  logic            detected_r;
  logic [3:0]      last_bits_r;
  logic            bit_s;

  assign bit_s = bit_sync_r[1];

  // Two-flop synchronizers for the three raw board inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_sync_r   <= 2'b00;
      step_sync_r  <= 2'b00;
      clear_sync_r <= 2'b00;
    end else begin
      bit_sync_r   <= {bit_sync_r[0], bus.bit_sw};
      step_sync_r  <= {step_sync_r[0], bus.step_btn};
      clear_sync_r <= {clear_sync_r[0], bus.clear_btn};
    end
  end

  // Debouncer: the level flips only after DEBOUNCE_CYCLES consecutive mismatches;
  // step is a registered strobe on the debounced rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_r    <= '0;
      db_level_r  <= 1'b0;
      step_prev_r <= 1'b0;
      step_r      <= 1'b0;
    end else begin
      step_prev_r <= db_level_r;
      step_r      <= db_level_r & ~step_prev_r;
      if (step_sync_r[1] != db_level_r) begin
        if (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_level_r <= ~db_level_r;
          db_cnt_r   <= '0;
        end else begin
          db_cnt_r <= db_cnt_r + 1'b1;
        end
      end else begin
        db_cnt_r <= '0;
      end
    end
  end

  // Pattern FSM with registered detect pulse, bit history and wrapping count;
  // clear outranks a coincident step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S0;
      count_r     <= 16'd0;
      detected_r  <= 1'b0;
      last_bits_r <= 4'b0000;
    end else if (clear_sync_r[1]) begin
      state_r     <= S0;
      count_r     <= 16'd0;
      detected_r  <= 1'b0;
      last_bits_r <= 4'b0000;
    end else begin
      detected_r <= 1'b0;
      if (step_r) begin
        last_bits_r <= {last_bits_r[2:0], bit_s};
        case (state_r)
          S0:      state_r <= bit_s ? S1 : S0;
          S1:      state_r <= bit_s ? S11 : S0;
          S11:     state_r <= bit_s ? S11 : S110;
          S110: begin
            if (bit_s) begin
              state_r    <= S1101;
              detected_r <= 1'b1;
              if (count_r == 16'(COUNT_MAX)) begin
                count_r <= 16'd0;
              end else begin
                count_r <= count_r + 16'd1;
              end
            end else begin
              state_r <= S0;
            end
          end
          S1101:   state_r <= bit_s ? S11 : S0;
          default: state_r <= S0;
        endcase
      end else begin
        case (state_r)
          S0, S1, S11, S110, S1101: state_r <= state_r;
          default:                  state_r <= S0;
        endcase
      end
    end
  end

  assign bus.count     = count_r;
  assign bus.detected  = detected_r;
  assign bus.state_out = state_r;
  assign bus.last_bits = last_bits_r;

endmodule

// File: doc/seq_detect_counter.md
# seq_detect_counter

Input front end and sequence-detecting FSM for the Basys 3 sequence-detector design. It synchronizes and debounces a step button, samples a data switch on each debounced press, and detects the overlapping serial pattern 1101. It keeps a decimal-range (0–9999) detection count that drives the seven-segment display controller's 16-bit `count` input directly.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required before the debounced button level changes (10 ms at 100 MHz); minimum 2.
- COUNT_MAX, 9999, highest count value; the next increment wraps to 0.

Ports:
- clk  input  1  100 MHz system clock.
- reset  input  1  asynchronous, active-high reset.
- bit_sw  input  1  raw data switch; its value is the serial bit presented on each step.
- step_btn  input  1  raw step pushbutton; each debounced press consumes one bit.
- clear_btn  input  1  raw clear pushbutton; synchronized only, not debounced.
- count  output  16  number of pattern detections, range 0..COUNT_MAX, binary-encoded.
- detected  output  1  one-cycle pulse on each detection.
- state_out  output  3  current FSM state encoding, for LEDs.
- last_bits  output  4  the last four accepted bits, newest in bit 0, for LEDs.

## Operation
- Synchronizers: bit_sw, step_btn and clear_btn each pass through a 2-flop synchronizer, reset to 0.
- Debounce of the synchronized step_btn:
  - The counter increments on every cycle where the synchronized input differs from the debounced level.
  - The counter resets to 0 on any cycle where they match.
  - When a mismatch is seen with the counter at DEBOUNCE_CYCLES-1, the debounced level toggles and the counter returns to 0.
- Strobe: `step` is high for one cycle when the debounced level goes 0→1. Releases generate no strobe.
- On a `step` cycle, the bit taken is the synchronized bit_sw in that cycle. last_bits shifts left, with the new bit entering bit 0.
- FSM states and encodings: S0=0, S1=1, S11=2, S110=3, S1101=4. Transitions on a `step` cycle:
  - S0: 1→S1, 0→S0.
  - S1: 1→S11, 0→S0.
  - S11: 1→S11, 0→S110.
  - S110: 1→S1101, 0→S0.
  - S1101: 1→S11, 0→S0 (overlap is allowed).
- Without `step`, the state holds. Unused encodings 5–7 return to S0 on the next clock.
- Detection: on the edge where the FSM enters S1101:
  - detected is registered high for exactly one cycle.
  - count increments; at COUNT_MAX it wraps to 0.
- Clear: synchronized clear_btn high forces, on that edge, count=0, state=S0, last_bits=0 and detected=0. Clear has priority over a simultaneous `step`. The debouncer is not affected.
- Reset (asynchronous, any time, including mid-debounce or mid-pattern): count=0, detected=0, state_out=0 (S0), last_bits=0. The synchronizers, debounced level and debounce counter also reset to 0.

## Timing
- All state updates occur on the rising edge of clk.
- Raw step_btn rise held stable → `step` high: 2 cycles (synchronizer) + DEBOUNCE_CYCLES cycles + 1 cycle (edge register).
- `step` → state_out, last_bits, count and detected updated: 1 edge. detected is high during the cycle following that edge.
- clear_btn → outputs cleared: 3 edges (2 synchronizer + 1).
- bit_sw must be stable for 2 cycles before `step`. It is normally static for milliseconds.
- count never leaves 0..COUNT_MAX, so every display digit stays 0–9.
- Glitches shorter than DEBOUNCE_CYCLES produce no `step`.

## Test plan
Run with DEBOUNCE_CYCLES=4.
1. Reset: assert reset mid-simulation with arbitrary inputs → count=0, detected=0, state_out=0, last_bits=0 immediately, without waiting for a clock edge.
2. Debounce: step_btn pulses of 3 cycles → no `step`. A pulse held for 10 cycles → exactly one `step`, 7 cycles after the rise.
3. Pattern: step bits 1,1,0,1 → state_out sequence 1,2,3,4; detected pulses once; count=1; last_bits=4'b1101.
4. Overlap: bits 1,1,0,1,1,0,1 → two detections; count=2; final state_out=4. Bits 1,1,0,0,1,1,0,1 → one detection.
5. Wrap: force count=9999, then feed 1101 → count=0 with a single detected pulse.
6. Clear vs. step: assert clear_btn so its synchronized level coincides with the `step` of the completing 1 in 1101 → count=0, state_out=0, no detected pulse.
